// File: rtl/skew_feeder.sv
// Loads an N x N matrix from RAM port B into a local store, then streams it
// onto N lanes as a diagonally skewed wavefront (lane i delayed by i cycles).
module skew_feeder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int N      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                transpose,
  input  logic                hold,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_dout,
  output logic [N*DATA_W-1:0] lane_data,
  output logic [N-1:0]        lane_valid,
  output logic                busy,
  output logic                done
);

  localparam int                T_W       = $clog2(2*N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N*N-1);
  localparam logic [T_W-1:0]    T_END     = T_W'(2*N-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   store [N*N];
  logic                tr;
  logic                cap_vld;
  logic [ADDR_W-1:0]   cap_idx;
  logic [T_W-1:0]      t;
  logic [N*DATA_W-1:0] nxt_data;
  logic [N-1:0]        nxt_valid;
  logic [ADDR_W-1:0]   idx;
  logic                load_last;
  logic                stream_last;

  // A read issued with ram_en/ram_addr registered at edge k returns data
  // after edge k+1, so the capture pipeline is a one-cycle copy of en/addr.
  assign load_last   = cap_vld && (cap_idx == LAST_ADDR);
  assign stream_last = !hold && (t == T_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)       state_nxt = S_LOAD;
      S_LOAD:   if (load_last)   state_nxt = S_STREAM;
      S_STREAM: if (stream_last) state_nxt = S_DONE;
      S_DONE:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    nxt_data  = '0;
    nxt_valid = '0;
    idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (t >= T_W'(i) && t < T_W'(i + N)) begin
        idx = tr ? ADDR_W'((32'(t) - i) * N + i)
                 : ADDR_W'(i * N + 32'(t) - i);
        nxt_data[i*DATA_W +: DATA_W] = store[idx];
        nxt_valid[i]                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      lane_data  <= '0;
      lane_valid <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tr         <= 1'b0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      t          <= '0;
      store      <= '{default: '0};
    end else begin
      cap_vld <= ram_en;
      cap_idx <= ram_addr;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            tr       <= transpose;
            ram_en   <= 1'b1;
            ram_addr <= '0;
            t        <= '0;
          end
        end
        S_LOAD: begin
          if (ram_en) begin
            if (ram_addr == LAST_ADDR) ram_en   <= 1'b0;
            else                       ram_addr <= ram_addr + 1'b1;
          end
          if (cap_vld) store[cap_idx] <= ram_dout;
        end
        S_STREAM: begin
          if (!hold) begin
            if (t == T_END) begin
              lane_data  <= '0;
              lane_valid <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              lane_data  <= nxt_data;
              lane_valid <= nxt_valid;
              t          <= t + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
